// File: rtl/alu_seq_param.sv
// Width-generic sequential ALU: single-cycle ADD/SUB/logic,
// iterative signed MUL (shift-add) and DIV (restoring).
module alu_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_low,
  output logic [WIDTH-1:0] result_high,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state, state_nx;

  logic [2*W-1:0] acc;
  logic [W-1:0]   mb;
  logic [CW-1:0]  cnt;
  logic           res_neg;
  logic           rem_neg;
  logic           ovf_pend;

  logic op_add, op_sub, op_mul, op_div;
  logic op_and, op_or, op_xor, op_ill;
  logic b_zero, last;

  logic [W:0]     sum;
  logic [W-1:0]   diff;
  logic [W-1:0]   abs_a, abs_b;
  logic           add_ovf, sub_ovf, div_ovf;
  logic [W:0]     mul_sum;
  logic [W:0]     rs;
  logic [W-1:0]   rdiff;
  logic           ge;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  assign op_add = opcode == 3'b000;
  assign op_sub = opcode == 3'b001;
  assign op_mul = opcode == 3'b010;
  assign op_div = opcode == 3'b011;
  assign op_and = opcode == 3'b100;
  assign op_or  = opcode == 3'b101;
  assign op_xor = opcode == 3'b110;
  assign op_ill = opcode == 3'b111;

  assign b_zero = b == '0;
  assign last   = cnt == CW'(W);
  assign busy   = state != S_IDLE;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;
  assign abs_a   = a[W-1] ? -a : a;
  assign abs_b   = b[W-1] ? -b : b;
  assign add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign sub_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  assign div_ovf = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? mb : '0};
  assign rs      = {acc[2*W-1:W], acc[W-1]};
  assign ge      = rs >= {1'b0, mb};
  assign rdiff   = rs[W-1:0] - mb;

  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (op_mul) begin
            state_nx = S_MUL;
          end else if (op_div && !b_zero) begin
            state_nx = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_low  <= '0;
      result_high <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      acc         <= '0;
      mb          <= '0;
      cnt         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      ovf_pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            ovf_pend    <= 1'b0;
            unique case (1'b1)
              op_add: begin
                result_low  <= sum[W-1:0];
                result_high <= {{(W-1){1'b0}}, sum[W]};
                overflow    <= add_ovf;
                done        <= 1'b1;
              end
              op_sub: begin
                result_low  <= diff;
                result_high <= {W{diff[W-1]}};
                overflow    <= sub_ovf;
                done        <= 1'b1;
              end
              op_mul: begin
                acc     <= {{W{1'b0}}, abs_b};
                mb      <= abs_a;
                res_neg <= a[W-1] ^ b[W-1];
              end
              op_div: begin
                if (b_zero) begin
                  result_low  <= '0;
                  result_high <= '0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                end else begin
                  acc      <= {{W{1'b0}}, abs_a};
                  mb       <= abs_b;
                  res_neg  <= a[W-1] ^ b[W-1];
                  rem_neg  <= a[W-1];
                  ovf_pend <= div_ovf;
                end
              end
              op_and: begin
                result_low  <= a & b;
                result_high <= '0;
                done        <= 1'b1;
              end
              op_or: begin
                result_low  <= a | b;
                result_high <= '0;
                done        <= 1'b1;
              end
              op_xor: begin
                result_low  <= a ^ b;
                result_high <= '0;
                done        <= 1'b1;
              end
              op_ill: begin
                result_low  <= '0;
                result_high <= '0;
                illegal_op  <= 1'b1;
                done        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (last) begin
            {result_high, result_low} <= prod_fix;
            done <= 1'b1;
            cnt  <= '0;
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (last) begin
            result_low  <= quo_fix;
            result_high <= rem_fix;
            overflow    <= ovf_pend;
            done        <= 1'b1;
            cnt         <= '0;
          end else begin
            acc <= {ge ? rdiff : rs[W-1:0], acc[W-2:0], ge};
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param at WIDTH=16 and WIDTH=8:
// directed corner steps plus random ops against an arithmetic model.
module tb_alu_seq_param;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ov;
    logic        dz;
    logic        il;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        start16 = 1'b0;
  logic        start8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;

  logic [15:0] lo16, hi16;
  logic        done16, busy16, ov16, dz16, il16;
  logic [7:0]  lo8, hi8;
  logic        done8, busy8, ov8, dz8, il8;

  bit          cur = 1'b0;
  logic [15:0] o_lo, o_hi;
  logic        o_done, o_busy, o_ov, o_dz, o_il;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .opcode(opcode),
    .a(a16), .b(b16), .result_low(lo16), .result_high(hi16),
    .done(done16), .busy(busy16), .overflow(ov16),
    .div_by_zero(dz16), .illegal_op(il16)
  );

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .opcode(opcode),
    .a(a8), .b(b8), .result_low(lo8), .result_high(hi8),
    .done(done8), .busy(busy8), .overflow(ov8),
    .div_by_zero(dz8), .illegal_op(il8)
  );

  always_comb begin
    o_lo   = cur ? {8'h00, lo8} : lo16;
    o_hi   = cur ? {8'h00, hi8} : hi16;
    o_done = cur ? done8 : done16;
    o_busy = cur ? busy8 : busy16;
    o_ov   = cur ? ov8 : ov16;
    o_dz   = cur ? dz8 : dz16;
    o_il   = cur ? il8 : il16;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int w, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
    res_t   m;
    longint mask, ua, ub, sa, sb, mn, mx, r;
    m    = '0;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    mn   = -(longint'(1) << (w - 1));
    mx   = (longint'(1) << (w - 1)) - 1;
    sa   = (ua > mx) ? ua - (longint'(1) << w) : ua;
    sb   = (ub > mx) ? ub - (longint'(1) << w) : ub;
    case (op)
      3'd0: begin
        r    = ua + ub;
        m.lo = 16'(r & mask);
        m.hi = 16'(r >> w);
        m.ov = (sa + sb > mx) || (sa + sb < mn);
      end
      3'd1: begin
        r    = sa - sb;
        m.lo = 16'(r & mask);
        m.hi = (r < 0 && r >= mn) || r > mx ? 16'(mask) : 16'h0;
        m.ov = (r > mx) || (r < mn);
      end
      3'd2: begin
        r    = sa * sb;
        m.lo = 16'(r & mask);
        m.hi = 16'((r >>> w) & mask);
      end
      3'd3: begin
        if (sb == 0) begin
          m.dz = 1'b1;
        end else if (sa == mn && sb == -1) begin
          m.lo = 16'(ua);
          m.ov = 1'b1;
        end else begin
          m.lo = 16'((sa / sb) & mask);
          m.hi = 16'((sa % sb) & mask);
        end
      end
      3'd4: m.lo = 16'(ua & ub);
      3'd5: m.lo = 16'(ua | ub);
      3'd6: m.lo = 16'(ua ^ ub);
      default: m.il = 1'b1;
    endcase
    return m;
  endfunction

  task automatic issue(input bit sel, input logic [2:0] op,
                       input logic [15:0] av, input logic [15:0] bv);
    res_t        e;
    int          w, lat, bc;
    bit          lng;
    logic [15:0] m;
    w   = sel ? 8 : 16;
    m   = sel ? 16'h00FF : 16'hFFFF;
    e   = model(w, op, av, bv);
    lng = (op == 3'd2) || (op == 3'd3 && (bv & m) != 16'h0);
    cur = sel;
    @(negedge clk);
    opcode = op;
    if (sel) begin
      start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start16 = 1'b1; a16 = av; b16 = bv;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
    opcode = 3'($urandom);
    lat = 0; bc = 0;
    while (!o_done && lat < 40) begin
      if (o_busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk("done", 32'(o_done), 32'd1);
    chk("latency", lat, lng ? w + 1 : 0);
    chk("busy_cycles", bc, lng ? w + 1 : 0);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    chk("low", 32'(o_lo), 32'(e.lo));
    chk("high", 32'(o_hi), 32'(e.hi));
    chk("overflow", 32'(o_ov), 32'(e.ov));
    chk("div_by_zero", 32'(o_dz), 32'(e.dz));
    chk("illegal_op", 32'(o_il), 32'(e.il));
    @(posedge clk); #1;
    chk("done_pulse", 32'(o_done), 32'd0);
    chk("hold_low", 32'(o_lo), 32'(e.lo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    res_t e;
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    bit          rs;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_low16", 32'(lo16), 32'd0);
    chk("rst_high16", 32'(hi16), 32'd0);
    chk("rst_flags16", {27'd0, done16, busy16, ov16, dz16, il16}, 32'd0);
    chk("rst_out8", {lo8, hi8}, 32'd0);
    chk("rst_flags8", {27'd0, done8, busy8, ov8, dz8, il8}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(0, 3'd0, 16'h7FFF, 16'h0001);
    chk("add_ovf_low", 32'(lo16), 32'h8000);
    chk("add_ovf_flag", 32'(ov16), 32'd1);
    issue(0, 3'd2, -16'sd3, 16'd7);
    chk("mul_neg", {hi16, lo16}, 32'hFFFF_FFEB);
    issue(0, 3'd3, -16'sd7, 16'd2);
    chk("div_neg", {hi16, lo16}, 32'hFFFF_FFFD);
    issue(0, 3'd3, 16'h8000, 16'hFFFF);
    chk("div_ovf", {15'd0, ov16, hi16}, {15'd0, 1'b1, 16'h0000});
    chk("div_ovf_low", 32'(lo16), 32'h8000);
    issue(0, 3'd3, 16'd5, 16'd0);
    chk("div_zero", 32'(dz16), 32'd1);
    issue(0, 3'd0, 16'd1, 16'd1);
    chk("add_after_dz", {13'd0, ov16, dz16, il16, lo16}, 32'd2);
    issue(0, 3'd7, 16'h1234, 16'h5678);
    issue(0, 3'd1, 16'h8000, 16'h0001);

    // start pulsed mid-operation must be ignored
    cur = 1'b0;
    @(negedge clk);
    opcode = 3'd2; a16 = 16'd100; b16 = 16'd200; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        start16 = 1'b1; opcode = 3'd0;
        a16 = 16'($urandom); b16 = 16'($urandom);
      end
      if (lat == 4) start16 = 1'b0;
    end
    chk("ign_latency", lat, 17);
    chk("ign_result", {hi16, lo16}, 32'h0000_4E20);
    @(posedge clk); #1;
    chk("ign_no_extra_done", 32'(done16), 32'd0);

    // reset in flight discards the operation
    @(negedge clk);
    opcode = 3'd2; a16 = 16'd100; b16 = 16'd200; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out", {hi16, lo16}, 32'd0);
    chk("midrst_flags", {27'd0, done16, busy16, ov16, dz16, il16}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) lat++;
    end
    chk("midrst_no_done", lat, 0);
    issue(0, 3'd6, 16'hF0F0, 16'h0FF0);
    chk("xor_after_rst", 32'(lo16), 32'h0000_FF00);

    issue(1, 3'd2, 16'h007F, 16'h0080);
    chk("mul8", {16'd0, hi8, lo8}, 32'h0000_C080);

    // start held high: op accepted in the done cycle, then every cycle
    cur = 1'b1;
    @(negedge clk);
    opcode = 3'd2; a8 = 8'h7F; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    opcode = 3'd0; a8 = 8'd3; b8 = 8'd4;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_mul_lat", lat, 9);
    chk("held_mul", {16'd0, hi8, lo8}, 32'h0000_C080);
    @(posedge clk); #1;
    chk("held_add_done", 32'(done8), 32'd1);
    chk("held_add", 32'(lo8), 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      e = model(8, 3'd0, {8'h00, a8}, {8'h00, b8});
      @(posedge clk); #1;
      chk("b2b_done", 32'(done8), 32'd1);
      chk("b2b_res", {hi8, lo8}, {e.hi[7:0], e.lo[7:0]});
    end
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_stop", 32'(done8), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rs  = 1'($urandom);
      rop = 3'($urandom);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: begin ra = rs ? 16'h0080 : 16'h8000; rb = 16'hFFFF; end
        2: ra = rs ? 16'h0080 : 16'h8000;
        3: rb = rs ? 16'h0080 : 16'h8000;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) rop = 3'd3;
      issue(rs, rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
